// File: rtl/alu_cpu_pkg.sv
// Shared constants, opcodes and FSM state encoding for the alu_cpu execution core.
package alu_cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_cpu_top_regfile.sv
// 8x8 register file: two combinational read ports, one synchronous write port,
// cleared by synchronous active-low reset.
module register_file
  import alu_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] registers [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) registers[i] <= '0;
    end else if (we) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata_a = registers[raddr_a];
  assign rdata_b = registers[raddr_b];

endmodule

// File: rtl/alu_cpu_top.sv
// Register-register execution core: rd = rs1 OP rs2, retired through a
// five-state command FSM (IDLE, DECODE, EXEC, WRITE, DONE).
module alu_cpu_top
  import alu_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_cmd,
  input  logic [2:0] op_in,
  input  logic [2:0] rd_in,
  input  logic [2:0] rs1_in,
  input  logic [2:0] rs2_in,
  output logic       cmd_done,
  output logic       z_flag_out,
  output logic       c_flag_out
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic              zr_q, zr_d, cr_q, cr_d;
  logic              z_flag_q, z_flag_d, c_flag_q, c_flag_d;
  logic              done_q, done_d;

  logic              rf_we;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   wide;

  register_file u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (res_q),
    .raddr_a (rs1_q),
    .raddr_b (rs2_q),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // ALU; SUB uses a 9-bit difference so bit DATA_W is the unsigned borrow.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SUB: begin
        wide    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = {a_q[DATA_W-2:0], 1'b0};
        alu_c   = a_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[DATA_W-1:1]};
        alu_c   = a_q[0];
      end
      default: alu_res = b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zr_d     = zr_q;
    cr_d     = cr_q;
    z_flag_d = z_flag_q;
    c_flag_d = c_flag_q;
    done_d   = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          op_d    = op_in;
          rd_d    = rd_in;
          rs1_d   = rs1_in;
          rs2_d   = rs2_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Operands captured here, so rd == rs1/rs2 reads the pre-write value.
        a_d     = rdata_a;
        b_d     = rdata_b;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_res;
        zr_d    = (alu_res == '0);
        cr_d    = alu_c;
        state_d = WRITE;
      end
      WRITE: begin
        rf_we    = 1'b1;
        z_flag_d = zr_q;
        c_flag_d = cr_q;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zr_q     <= 1'b0;
      cr_q     <= 1'b0;
      z_flag_q <= 1'b0;
      c_flag_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zr_q     <= zr_d;
      cr_q     <= cr_d;
      z_flag_q <= z_flag_d;
      c_flag_q <= c_flag_d;
      done_q   <= done_d;
    end
  end

  assign cmd_done   = done_q;
  assign z_flag_out = z_flag_q;
  assign c_flag_out = c_flag_q;

endmodule

// File: tb/tb_alu_cpu_top.sv
// Directed bench for alu_cpu_top: hand-computed results, flags, done timing,
// start-during-busy and reset-mid-command.
module tb_alu_cpu_top;

  logic       clk;
  logic       rst_n;
  logic       start_cmd;
  logic [2:0] op_in, rd_in, rs1_in, rs2_in;
  logic       cmd_done, z_flag_out, c_flag_out;

  int total = 0;
  int bad   = 0;

  alu_cpu_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_cmd  (start_cmd),
    .op_in      (op_in),
    .rd_in      (rd_in),
    .rs1_in     (rs1_in),
    .rs2_in     (rs2_in),
    .cmd_done   (cmd_done),
    .z_flag_out (z_flag_out),
    .c_flag_out (c_flag_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command, wait (bounded) for cmd_done, check latency, result, flags, pulse width.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [7:0] exp_val, input logic exp_z, input logic exp_c);
    int cyc;
    cyc = 0;
    @(negedge clk);
    start_cmd = 1'b1;
    op_in = op; rd_in = rd; rs1_in = rs1; rs2_in = rs2;
    @(posedge clk);
    @(negedge clk);
    start_cmd = 1'b0;
    op_in  = 3'($urandom_range(0, 7));
    rd_in  = 3'($urandom_range(0, 7));
    rs1_in = 3'($urandom_range(0, 7));
    rs2_in = 3'($urandom_range(0, 7));
    while (cmd_done !== 1'b1 && cyc < 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_val({tag, "_lat"}, cyc, 3);
    check_val({tag, "_val"}, dut.u_regfile.registers[rd], exp_val);
    check_val({tag, "_z"}, z_flag_out, exp_z);
    check_val({tag, "_c"}, c_flag_out, exp_c);
    @(negedge clk);
    check_val({tag, "_pulse"}, cmd_done, 1'b0);
    check_val({tag, "_zhold"}, z_flag_out, exp_z);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    start_cmd = 1'b0;
    op_in = '0; rd_in = '0; rs1_in = '0; rs2_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_done", cmd_done, 1'b0);
    check_val("rst_z", z_flag_out, 1'b0);
    check_val("rst_c", c_flag_out, 1'b0);
    check_val("rst_r3", dut.u_regfile.registers[3], 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    dut.u_regfile.registers[1] = 8'h10;
    dut.u_regfile.registers[2] = 8'h0A;
    dut.u_regfile.registers[3] = 8'hFF;

    // driver: directed vectors
    run_cmd("add",   3'b000, 3'd4, 3'd1, 3'd2, 8'h1A, 1'b0, 1'b0);
    run_cmd("sub1",  3'b001, 3'd5, 3'd4, 3'd2, 8'h10, 1'b0, 1'b0);
    run_cmd("sub0",  3'b001, 3'd6, 3'd5, 3'd1, 8'h00, 1'b1, 1'b0);
    run_cmd("addc",  3'b000, 3'd7, 3'd3, 3'd2, 8'h09, 1'b0, 1'b1);
    run_cmd("subb",  3'b001, 3'd0, 3'd2, 3'd1, 8'hFA, 1'b0, 1'b1);
    run_cmd("and",   3'b010, 3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 1'b0);
    run_cmd("or",    3'b011, 3'd0, 3'd1, 3'd2, 8'h1A, 1'b0, 1'b0);
    run_cmd("xor",   3'b100, 3'd0, 3'd3, 3'd2, 8'hF5, 1'b0, 1'b0);
    run_cmd("mov",   3'b111, 3'd0, 3'd1, 3'd2, 8'h0A, 1'b0, 1'b0);
    run_cmd("shl",   3'b101, 3'd0, 3'd3, 3'd0, 8'hFE, 1'b0, 1'b1);
    run_cmd("shr",   3'b110, 3'd0, 3'd1, 3'd0, 8'h08, 1'b0, 1'b0);
    run_cmd("rdrs1", 3'b000, 3'd1, 3'd1, 3'd1, 8'h20, 1'b0, 1'b0);

    // start pulsed while in EXEC must be ignored
    @(negedge clk);
    start_cmd = 1'b1; op_in = 3'b000; rd_in = 3'd0; rs1_in = 3'd1; rs2_in = 3'd2;
    @(posedge clk);
    @(negedge clk);
    start_cmd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_cmd = 1'b1; op_in = 3'b001; rd_in = 3'd3; rs1_in = 3'd2; rs2_in = 3'd1;
    @(posedge clk);
    @(negedge clk);
    start_cmd = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (cmd_done === 1'b1) cnt++;
    end
    check_val("busy_done_cnt", cnt, 1);
    check_val("busy_r0", dut.u_regfile.registers[0], 8'h2A);
    check_val("busy_r3", dut.u_regfile.registers[3], 8'hFF);

    // leave C set so the reset clear is observable
    run_cmd("shl2", 3'b101, 3'd6, 3'd3, 3'd0, 8'hFE, 1'b0, 1'b1);

    // reset asserted for one edge while in EXEC
    @(negedge clk);
    start_cmd = 1'b1; op_in = 3'b000; rd_in = 3'd4; rs1_in = 3'd3; rs2_in = 3'd2;
    @(posedge clk);
    @(negedge clk);
    start_cmd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (cmd_done === 1'b1) cnt++;
    end
    check_val("rstx_done_cnt", cnt, 0);
    check_val("rstx_z", z_flag_out, 1'b0);
    check_val("rstx_c", c_flag_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("rstx_r%0d", i), dut.u_regfile.registers[i], 8'h00);
    end

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
